// File: rtl/pid_sample_sequencer_if.sv
// ADC conversion handshake between the PID sample sequencer and the SPI master.
interface pid_sample_sequencer_if #(
    parameter int unsigned ADC_WIDTH = 8
);
    logic                 adc_start;
    logic                 adc_busy;
    logic                 adc_done;
    logic [ADC_WIDTH-1:0] adc_data;

    modport master (
        output adc_start,
        input  adc_busy,
        input  adc_done,
        input  adc_data
    );

    modport slave (
        input  adc_start,
        output adc_busy,
        output adc_done,
        output adc_data
    );
endinterface

// File: rtl/pid_sample_sequencer.sv
// Runs one PID update per sample period: ADC request, sample latch, then
// one-cycle enables for the shift, integrate and sum stages in order.
module pid_sample_sequencer #(
    parameter int unsigned ADC_WIDTH   = 8,
    parameter int unsigned SAMPLE_DIV  = 1000,
    parameter int unsigned ADC_TIMEOUT = 64,
    parameter int unsigned TICK_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      enable,
    input  logic                      err_clr,
    pid_sample_sequencer_if.master    adc,
    output logic [ADC_WIDTH-1:0]      cur_vd,
    output logic                      sr_enable,
    output logic                      int_enable,
    output logic                      sum_enable,
    output logic                      update_valid,
    output logic                      timeout_err,
    output logic [7:0]                overrun_cnt
);

    localparam int unsigned TO_WIDTH = $clog2(ADC_TIMEOUT);
    localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(SAMPLE_DIV - 1);
    localparam logic [TO_WIDTH-1:0]   TO_LAST   = TO_WIDTH'(ADC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ADC,
        S_LATCH,
        S_SHIFT,
        S_INTEG,
        S_SUM,
        S_DONE
    } state_t;

    state_t                state;
    logic [TICK_WIDTH-1:0] tick_cnt;
    logic [TO_WIDTH-1:0]   to_cnt;
    logic                  tick_c;
    logic                  overrun_c;
    logic                  timeout_c;

    assign tick_c    = enable && (tick_cnt == TICK_LAST);
    // A tick is lost when a sequence is still running or the SPI master is busy.
    assign overrun_c = tick_c && ((state != S_IDLE) || adc.adc_busy);
    assign timeout_c = (state == S_WAIT_ADC) && !adc.adc_done && (to_cnt == TO_LAST);

    // Sample-period counter; parked at zero while disabled.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tick_cnt <= '0;
        end else if (!enable || (tick_cnt == TICK_LAST)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_WIDTH'(1);
        end
    end

    // Sequencer FSM; every pulse is registered on entry to the state it belongs to.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= S_IDLE;
            to_cnt        <= '0;
            cur_vd        <= '0;
            adc.adc_start <= 1'b0;
            sr_enable     <= 1'b0;
            int_enable    <= 1'b0;
            sum_enable    <= 1'b0;
            update_valid  <= 1'b0;
            timeout_err   <= 1'b0;
            overrun_cnt   <= 8'd0;
        end else begin
            adc.adc_start <= 1'b0;
            sr_enable     <= 1'b0;
            int_enable    <= 1'b0;
            sum_enable    <= 1'b0;
            update_valid  <= 1'b0;

            if (overrun_c && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end

            // A fresh timeout beats a simultaneous clear.
            if (timeout_c) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (tick_c && !adc.adc_busy) begin
                        state         <= S_START;
                        adc.adc_start <= 1'b1;
                    end
                end
                S_START: begin
                    to_cnt <= '0;
                    state  <= S_WAIT_ADC;
                end
                S_WAIT_ADC: begin
                    if (adc.adc_done) begin
                        cur_vd <= adc.adc_data;
                        state  <= S_LATCH;
                    end else if (to_cnt == TO_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_WIDTH'(1);
                    end
                end
                S_LATCH: begin
                    sr_enable <= 1'b1;
                    state     <= S_SHIFT;
                end
                S_SHIFT: begin
                    int_enable <= 1'b1;
                    state      <= S_INTEG;
                end
                S_INTEG: begin
                    sum_enable <= 1'b1;
                    state      <= S_SUM;
                end
                S_SUM: begin
                    update_valid <= 1'b1;
                    state        <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pid_sample_sequencer.sv
// Directed bench for pid_sample_sequencer: scoreboarded pulse schedule on a
// SAMPLE_DIV=20 instance, overrun/saturation checks on a SAMPLE_DIV=4 instance.
module tb_pid_sample_sequencer;

    localparam int unsigned AW = 8;

    logic clk;
    logic n_rst;
    logic enable;
    logic err_clr;

    pid_sample_sequencer_if #(.ADC_WIDTH(AW)) adc_a ();
    pid_sample_sequencer_if #(.ADC_WIDTH(AW)) adc_b ();

    logic [AW-1:0] a_cur_vd, b_cur_vd;
    logic          a_sr, a_int, a_sum, a_uv, a_terr;
    logic          b_sr, b_int, b_sum, b_uv, b_terr;
    logic [7:0]    a_ovr, b_ovr;

    pid_sample_sequencer #(
        .ADC_WIDTH(AW), .SAMPLE_DIV(20), .ADC_TIMEOUT(8), .TICK_WIDTH(16)
    ) u_dut_a (
        .clk(clk), .n_rst(n_rst), .enable(enable), .err_clr(err_clr),
        .adc(adc_a), .cur_vd(a_cur_vd),
        .sr_enable(a_sr), .int_enable(a_int), .sum_enable(a_sum),
        .update_valid(a_uv), .timeout_err(a_terr), .overrun_cnt(a_ovr)
    );

    pid_sample_sequencer #(
        .ADC_WIDTH(AW), .SAMPLE_DIV(4), .ADC_TIMEOUT(8), .TICK_WIDTH(16)
    ) u_dut_b (
        .clk(clk), .n_rst(n_rst), .enable(enable), .err_clr(err_clr),
        .adc(adc_b), .cur_vd(b_cur_vd),
        .sr_enable(b_sr), .int_enable(b_int), .sum_enable(b_sum),
        .update_valid(b_uv), .timeout_err(b_terr), .overrun_cnt(b_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse kinds: 0 adc_start, 1 sr_enable, 2 int_enable, 3 sum_enable, 4 update_valid.
    typedef struct packed {
        int kind;
        int cyc;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        ev;
    int         checks = 0;
    int         errors = 0;
    int         cyc;
    bit         a_mon = 1'b0;
    bit         b_mon = 1'b0;
    int         b_starts = 0;
    logic [4:0] pa;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic expect_ev(input int kind, input int c);
        exp_q.push_back('{kind: kind, cyc: c});
    endtask

    task automatic expect_seq(input int d);
        expect_ev(1, d + 2);
        expect_ev(2, d + 3);
        expect_ev(3, d + 4);
        expect_ev(4, d + 5);
    endtask

    task automatic done_a(input int n, input logic [AW-1:0] data);
        goto_cyc(n);
        adc_a.adc_done = 1'b1;
        adc_a.adc_data = data;
        goto_cyc(n + 1);
        adc_a.adc_done = 1'b0;
        adc_a.adc_data = '0;
    endtask

    // Cycle index: number of rising edges since reset release.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Scoreboard for instance A: every pulse must match the head of the queue.
    always @(negedge clk) begin
        if (a_mon && n_rst) begin
            pa = {a_uv, a_sum, a_int, a_sr, adc_a.adc_start};
            if (pa != 5'd0) begin
                chk("pulse_onehot", $countones(pa), 1);
                for (int k = 0; k < 5; k++) begin
                    if (pa[k]) begin
                        if (exp_q.size() == 0) begin
                            chk("pulse_unexpected", k * 10000 + cyc, 32'hFFFF_FFFF);
                        end else begin
                            ev = exp_q.pop_front();
                            chk("pulse_kind_cyc", k * 10000 + cyc, ev.kind * 10000 + ev.cyc);
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b_mon && n_rst && adc_b.adc_start) b_starts <= b_starts + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst   = 1'b0;
        enable  = 1'b1;
        err_clr = 1'b0;
        adc_a.adc_busy = 1'b0; adc_a.adc_done = 1'b0; adc_a.adc_data = '0;
        adc_b.adc_busy = 1'b0; adc_b.adc_done = 1'b0; adc_b.adc_data = '0;
        a_mon = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pulses", {27'd0, a_uv, a_sum, a_int, a_sr, adc_a.adc_start}, 0);
        chk("rst_cur_vd", a_cur_vd, 0);
        chk("rst_terr", a_terr, 0);
        chk("rst_ovr", a_ovr, 0);
        @(negedge clk);
        expect_ev(0, 20);
        n_rst = 1'b1;

        // No ADC answer: 8 wait cycles then timeout, no stage pulses.
        goto_cyc(28); chk("to_before", a_terr, 0);
        goto_cyc(29); chk("to_set", a_terr, 1);
        chk("to_cur_vd", a_cur_vd, 0);
        chk("to_q_empty", exp_q.size(), 0);
        goto_cyc(30); err_clr = 1'b1;
        goto_cyc(31); err_clr = 1'b0;
        chk("err_clr", a_terr, 0);

        // Done three cycles after adc_start.
        expect_ev(0, 40);
        expect_seq(43);
        goto_cyc(43); chk("vd_before_done", a_cur_vd, 0);
        done_a(43, 8'hA5);
        chk("vd_a5", a_cur_vd, 8'hA5);
        goto_cyc(49); chk("seq2_q_empty", exp_q.size(), 0);

        // Busy across two ticks, then a minimum-latency answer.
        goto_cyc(59); adc_a.adc_busy = 1'b1;
        goto_cyc(60); chk("busy_ovr1", a_ovr, 1);
        goto_cyc(80); chk("busy_ovr2", a_ovr, 2);
        goto_cyc(81); adc_a.adc_busy = 1'b0;
        expect_ev(0, 100);
        expect_seq(101);
        done_a(101, 8'h3C);
        chk("vd_3c", a_cur_vd, 8'h3C);
        goto_cyc(107); chk("seq3_q_empty", exp_q.size(), 0);
        chk("seq3_ovr", a_ovr, 2);

        // Done on the last wait cycle wins over the timeout.
        expect_ev(0, 120);
        expect_seq(128);
        done_a(128, 8'h5A);
        chk("vd_5a", a_cur_vd, 8'h5A);
        goto_cyc(134); chk("late_done_terr", a_terr, 0);
        chk("seq4_q_empty", exp_q.size(), 0);

        // err_clr coincident with a new timeout: set wins.
        expect_ev(0, 140);
        goto_cyc(148); chk("clr_race_before", a_terr, 0);
        err_clr = 1'b1;
        goto_cyc(149); err_clr = 1'b0;
        chk("clr_race_set", a_terr, 1);
        chk("to_vd_hold", a_cur_vd, 8'h5A);

        // enable dropped mid-wait: sequence finishes, then no new requests.
        expect_ev(0, 160);
        goto_cyc(162); enable = 1'b0;
        expect_seq(164);
        done_a(164, 8'h77);
        chk("vd_77", a_cur_vd, 8'h77);
        goto_cyc(220); chk("dis_q_empty", exp_q.size(), 0);
        chk("dis_ovr", a_ovr, 2);
        enable = 1'b1;

        // Reset asserted while int_enable is high.
        expect_ev(0, 240);
        expect_ev(1, 244);
        expect_ev(2, 245);
        done_a(242, 8'h99);
        goto_cyc(245);
        #2 n_rst = 1'b0;
        #1;
        chk("mid_rst_pulses", {27'd0, a_uv, a_sum, a_int, a_sr, adc_a.adc_start}, 0);
        chk("mid_rst_cur_vd", a_cur_vd, 0);
        chk("mid_rst_ovr", a_ovr, 0);
        chk("mid_rst_terr", a_terr, 0);
        chk("mid_rst_q_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        expect_ev(0, 20);
        n_rst = 1'b1;
        goto_cyc(30);
        chk("post_rst_terr", a_terr, 1);
        chk("post_rst_q_empty", exp_q.size(), 0);

        // Instance B: short period, slow ADC, then saturation.
        a_mon = 1'b0;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        b_mon = 1'b1;
        n_rst = 1'b1;
        goto_cyc(4);  chk("b_start", adc_b.adc_start, 1);
        goto_cyc(7);  chk("b_ovr0", b_ovr, 0);
        goto_cyc(8);  chk("b_ovr1", b_ovr, 1);
        goto_cyc(10); adc_b.adc_done = 1'b1; adc_b.adc_data = 8'hC3;
        goto_cyc(11); adc_b.adc_done = 1'b0; adc_b.adc_data = '0;
        chk("b_vd", b_cur_vd, 8'hC3);
        goto_cyc(12); chk("b_ovr2", b_ovr, 2); chk("b_sr", b_sr, 1);
        goto_cyc(13); chk("b_int", b_int, 1);
        goto_cyc(14); chk("b_sum", b_sum, 1);
        goto_cyc(15); chk("b_uv", b_uv, 1);
        goto_cyc(16); chk("b_ovr3", b_ovr, 3);
        goto_cyc(17); adc_b.adc_busy = 1'b1;
        goto_cyc(1217);
        chk("b_ovr_sat", b_ovr, 255);
        chk("b_starts", b_starts, 1);
        chk("b_terr", b_terr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pid_sample_sequencer.md
Name: pid_sample_sequencer

Overview:
- Sequences one PID control update per sample period.
- Each period it requests an ADC conversion over the SPI master handshake and latches the returned voltage sample.
- It then pulses the enables of the PID pipeline stages in fixed order: error shift register, integral accumulate, sum.
- It sits between the SPI/ADC front end and the PID datapath, replacing the tied-high enables with a timed schedule.

Parameters:
- ADC_WIDTH, 8, width of ADC sample and cur_vd.
- SAMPLE_DIV, 1000, clk cycles per sample period; legal range is at least 2.
- ADC_TIMEOUT, 64, maximum cycles spent in WAIT_ADC before abort; legal range is at least 2.
- TICK_WIDTH, 16, width of the sample-period counter; must satisfy 2^TICK_WIDTH >= SAMPLE_DIV.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- enable  in  1  run control; low halts the sample tick.
- err_clr  in  1  clears timeout_err.
- adc_start  out  1  one-cycle conversion request to the SPI master.
- adc_busy  in  1  SPI master busy.
- adc_done  in  1  one-cycle pulse, adc_data valid.
- adc_data  in  ADC_WIDTH  conversion result.
- cur_vd  out  ADC_WIDTH  latched sample for the error calculator.
- sr_enable  out  1  one-cycle shift pulse to the error shift register.
- int_enable  out  1  one-cycle accumulate pulse to the integral stage.
- sum_enable  out  1  one-cycle pulse to the PID sum stage.
- update_valid  out  1  one-cycle pulse: new PID output available.
- timeout_err  out  1  sticky ADC timeout flag.
- overrun_cnt  out  8  saturating count of dropped sample ticks.

Behaviour:
- Reset: all outputs 0, cur_vd = 0, tick counter = 0, timeout counter = 0, state = IDLE.
- Tick counter:
  - While enable = 1, counts 0..SAMPLE_DIV-1 and wraps.
  - tick is asserted internally for the one cycle where count = SAMPLE_DIV-1.
  - While enable = 0, the counter is held at 0 and no tick occurs.
  - A sequence already in progress runs to completion regardless of enable.
- FSM states: IDLE, START, WAIT_ADC, LATCH, SHIFT, INTEG, SUM, DONE.
  - IDLE: on tick with adc_busy = 0 -> START. On tick with adc_busy = 1 -> stay in IDLE and increment overrun_cnt.
  - START: adc_start = 1 for exactly this cycle; clear the timeout counter; -> WAIT_ADC.
  - WAIT_ADC: on adc_done = 1, register cur_vd <= adc_data in that same cycle and -> LATCH.
    - Otherwise increment the timeout counter.
    - When the counter reaches ADC_TIMEOUT-1 without adc_done: set timeout_err, leave cur_vd unchanged, -> IDLE. No stage enables pulse.
  - LATCH: one settle cycle so the error calculator can register the new cur_vd; -> SHIFT.
  - SHIFT: sr_enable = 1; -> INTEG.
  - INTEG: int_enable = 1; -> SUM.
  - SUM: sum_enable = 1; -> DONE.
  - DONE: update_valid = 1; -> IDLE.
- Latency: with adc_done seen in cycle N, cur_vd updates at the N+1 edge. sr_enable is high in N+2, int_enable in N+3, sum_enable in N+4, update_valid in N+5.
- adc_start to first possible adc_done: one cycle minimum.
- Pulse rule: at most one of adc_start/sr_enable/int_enable/sum_enable/update_valid is high in any cycle. Each is high for exactly one cycle per sequence.
- A tick arriving in any state other than IDLE is dropped and increments overrun_cnt. overrun_cnt saturates at 255.
- adc_done outside WAIT_ADC is ignored; cur_vd is not updated.
- adc_done in the same cycle the timeout would fire: done wins, no timeout_err.
- err_clr clears timeout_err next edge. If a new timeout occurs in the same cycle as err_clr, set wins and timeout_err stays 1.
- overrun_cnt is cleared only by reset.
- Reset asserted mid-sequence: immediate return to reset values; no partial pulses after release. The first sequence after release needs a full SAMPLE_DIV ticks.

Test Plan:
- SAMPLE_DIV=20, ADC_TIMEOUT=8, enable=1 from reset release, no other stimulus:
  - adc_start high in cycle 20 only.
  - No adc_done -> timeout_err=1 after 8 WAIT_ADC cycles, no sr/int/sum pulses, cur_vd=0.
- Same setup, model returns adc_done with adc_data=0xA5 three cycles after adc_start:
  - cur_vd=0xA5 one cycle later.
  - sr_enable, int_enable, sum_enable, update_valid in consecutive cycles at done+2..done+5, each exactly one cycle wide.
- adc_busy=1 held across two ticks: overrun_cnt=2, no adc_start. adc_busy=0 before the third tick: normal sequence.
- SAMPLE_DIV=4, ADC_TIMEOUT=8, adc_done delayed 6 cycles:
  - Ticks during the sequence increment overrun_cnt.
  - Force 300 ticks -> overrun_cnt holds at 255.
- adc_done arrives on the last timeout cycle -> sequence completes, timeout_err stays 0. Separately, err_clr pulsed together with a fresh timeout -> timeout_err remains 1.
- Drop n_rst while in INTEG -> all outputs 0 asynchronously, cur_vd=0. Drop enable mid-WAIT_ADC -> sequence completes, no further adc_start while enable=0.
